// File: rtl/alsu_if.sv
// Switch/LED bundle of the ALSU. The board side drives operands and controls,
// and the ALSU returns the registered result and the invalid-operation LED bank.
interface alsu_if #(
  parameter int BITS = 3
);
  logic              cin;
  logic              SI;
  logic              sh_left;
  logic              red_op_A;
  logic              red_op_B;
  logic              pass_A;
  logic              pass_B;
  logic [BITS-1:0]   A;
  logic [BITS-1:0]   B;
  logic [2:0]        opcode;
  logic [15:0]       leds;
  logic [2*BITS-1:0] out;

  modport master (
    output cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B, A, B, opcode,
    input  leds, out
  );

  modport slave (
    input  cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B, A, B, opcode,
    output leds, out
  );
endinterface

// File: rtl/alsu.sv
// Registered arithmetic-logic-shift unit: inputs are captured on one edge and
// the 2*BITS result and invalid-operation LEDs are registered on the next.
module alsu #(
  parameter int BITS           = 3,
  parameter     INPUT_PRIORITY = "A",
  parameter     FULL_ADDER     = "ON"
) (
  input logic   clk,
  input logic   rstn,
  alsu_if.slave bus
);
  localparam int OUT_W = 2 * BITS;
  localparam bit PRIO_A = (INPUT_PRIORITY == "A");
  localparam bit USE_CIN = (FULL_ADDER == "ON");

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_XOR = 3'b001,
    OP_ADD = 3'b010,
    OP_MUL = 3'b011,
    OP_SHF = 3'b100,
    OP_ROT = 3'b101,
    OP_BAD0 = 3'b110,
    OP_BAD1 = 3'b111
  } opcode_e;

  logic [BITS-1:0] a_r, b_r;
  logic            cin_r, si_r, sh_left_r;
  logic            red_a_r, red_b_r, pass_a_r, pass_b_r;
  opcode_e         opcode_r;

  logic [OUT_W-1:0] out_r, next_out;
  logic [15:0]      leds_r, next_leds;
  logic             invalid;
  logic             use_b_red;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_r       <= '0;
      b_r       <= '0;
      cin_r     <= 1'b0;
      si_r      <= 1'b0;
      sh_left_r <= 1'b0;
      red_a_r   <= 1'b0;
      red_b_r   <= 1'b0;
      pass_a_r  <= 1'b0;
      pass_b_r  <= 1'b0;
      opcode_r  <= OP_AND;
      out_r     <= '0;
      leds_r    <= '0;
    end else begin
      a_r       <= bus.A;
      b_r       <= bus.B;
      cin_r     <= bus.cin;
      si_r      <= bus.SI;
      sh_left_r <= bus.sh_left;
      red_a_r   <= bus.red_op_A;
      red_b_r   <= bus.red_op_B;
      pass_a_r  <= bus.pass_A;
      pass_b_r  <= bus.pass_B;
      opcode_r  <= opcode_e'(bus.opcode);
      out_r     <= next_out;
      leds_r    <= next_leds;
    end
  end

  // Reduction flags are only legal with AND/XOR; anything else is invalid.
  assign invalid = (opcode_r == OP_BAD0) || (opcode_r == OP_BAD1) ||
                   ((red_a_r || red_b_r) && (opcode_r != OP_AND) && (opcode_r != OP_XOR));
  assign use_b_red = red_b_r && (!red_a_r || !PRIO_A);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    next_out  = '0;
    next_leds = '0;
    if (pass_a_r && pass_b_r) begin
      next_out = PRIO_A ? OUT_W'(a_r) : OUT_W'(b_r);
    end else if (pass_a_r) begin
      next_out = OUT_W'(a_r);
    end else if (pass_b_r) begin
      next_out = OUT_W'(b_r);
    end else if (invalid) begin
      next_leds = ~leds_r;
    end else begin
      case (opcode_r)
        OP_AND: begin
          if (use_b_red)    next_out = OUT_W'(&b_r);
          else if (red_a_r) next_out = OUT_W'(&a_r);
          else              next_out = OUT_W'(a_r & b_r);
        end
        OP_XOR: begin
          if (use_b_red)    next_out = OUT_W'(^b_r);
          else if (red_a_r) next_out = OUT_W'(^a_r);
          else              next_out = OUT_W'(a_r ^ b_r);
        end
        OP_ADD: next_out = OUT_W'(a_r) + OUT_W'(b_r) + OUT_W'(USE_CIN && cin_r);
        OP_MUL: next_out = OUT_W'(a_r) * OUT_W'(b_r);
        OP_SHF: next_out = sh_left_r ? {out_r[OUT_W-2:0], si_r}
                                     : {si_r, out_r[OUT_W-1:1]};
        OP_ROT: next_out = sh_left_r ? {out_r[OUT_W-2:0], out_r[OUT_W-1]}
                                     : {out_r[0], out_r[OUT_W-1:1]};
        default: next_out = '0;
      endcase
    end
  end

  assign bus.out  = out_r;
  assign bus.leds = leds_r;
endmodule

// File: tb/tb_alsu.sv
// Directed bench for alsu (BITS=3, INPUT_PRIORITY="B", FULL_ADDER="ON"):
// a vector table for steady-state ops plus hand sequences for shift/rotate/LEDs.
module tb_alsu;
  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alsu_if #(.BITS(3)) bus ();

  alsu #(
    .BITS(3),
    .INPUT_PRIORITY("B"),
    .FULL_ADDER("ON")
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  typedef struct {
    string      name;
    logic       pass_a, pass_b, red_a, red_b, cin;
    logic [2:0] opcode;
    logic [2:0] a, b;
    logic [5:0] exp_out;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pass_a, input logic pass_b, input logic red_a,
                       input logic red_b, input logic cin, input logic [2:0] opcode,
                       input logic [2:0] a, input logic [2:0] b,
                       input logic sh_left, input logic si);
    bus.pass_A   = pass_a;
    bus.pass_B   = pass_b;
    bus.red_op_A = red_a;
    bus.red_op_B = red_b;
    bus.cin      = cin;
    bus.opcode   = opcode;
    bus.A        = a;
    bus.B        = b;
    bus.sh_left  = sh_left;
    bus.SI       = si;
  endtask

  initial begin
    vecs[0]  = '{"mul_5x3",      0, 0, 0, 0, 0, 3'b011, 3'd5, 3'd3, 6'd15};
    vecs[1]  = '{"and_6_3",      0, 0, 0, 0, 0, 3'b000, 3'd6, 3'd3, 6'd2};
    vecs[2]  = '{"xor_6_3",      0, 0, 0, 0, 0, 3'b001, 3'd6, 3'd3, 6'd5};
    vecs[3]  = '{"add_max",      0, 0, 0, 0, 1, 3'b010, 3'd7, 3'd7, 6'd15};
    vecs[4]  = '{"mul_max",      0, 0, 0, 0, 0, 3'b011, 3'd7, 3'd7, 6'd49};
    vecs[5]  = '{"add_no_cin",   0, 0, 0, 0, 0, 3'b010, 3'd2, 3'd3, 6'd5};
    vecs[6]  = '{"pass_both",    1, 1, 0, 0, 0, 3'b000, 3'd5, 3'd2, 6'd2};
    vecs[7]  = '{"pass_a_bad_op",1, 0, 0, 0, 0, 3'b111, 3'd5, 3'd2, 6'd5};
    vecs[8]  = '{"xor_red_both", 0, 0, 1, 1, 0, 3'b001, 3'd7, 3'd5, 6'd0};
    vecs[9]  = '{"and_red_a",    0, 0, 1, 0, 0, 3'b000, 3'd7, 3'd2, 6'd1};
    vecs[10] = '{"and_red_both", 0, 0, 1, 1, 0, 3'b000, 3'd3, 3'd7, 6'd1};
    vecs[11] = '{"xor_red_a",    0, 0, 1, 0, 0, 3'b001, 3'd7, 3'd0, 6'd1};
    vecs[12] = '{"pass_b_add",   0, 1, 0, 0, 1, 3'b010, 3'd1, 3'd6, 6'd6};

    // Reset held with an ADD presented; release and expect 5+1+1 two edges later.
    rstn = 1'b0;
    drive(0, 0, 0, 0, 1, 3'b010, 3'd5, 3'd1, 0, 0);
    repeat (3) tick();
    check("rst_out", 16'(bus.out), 16'h0);
    check("rst_leds", bus.leds, 16'h0);
    rstn = 1'b1;
    tick();
    tick();
    check("add_after_rst", 16'(bus.out), 16'd7);

    foreach (vecs[i]) begin
      drive(vecs[i].pass_a, vecs[i].pass_b, vecs[i].red_a, vecs[i].red_b, vecs[i].cin,
            vecs[i].opcode, vecs[i].a, vecs[i].b, 0, 0);
      tick();
      tick();
      check(vecs[i].name, 16'(bus.out), 16'(vecs[i].exp_out));
      check({vecs[i].name, "_leds"}, bus.leds, 16'h0);
    end

    // Reduction flag with ADD is invalid: out 0, LEDs toggle each cycle.
    drive(0, 0, 1, 0, 0, 3'b010, 3'd5, 3'd1, 0, 0);
    tick();
    tick();
    check("red_add_out", 16'(bus.out), 16'h0);
    check("red_add_leds1", bus.leds, 16'hFFFF);
    tick();
    check("red_add_leds2", bus.leds, 16'h0000);
    tick();
    check("red_add_leds3", bus.leds, 16'hFFFF);

    // Load 000111 via pass, then shift left with SI=1, then right with SI=0.
    drive(1, 0, 0, 0, 0, 3'b000, 3'd7, 3'd0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 3'b100, 3'd0, 3'd0, 1, 1);
    tick();
    check("shf_load", 16'(bus.out), 16'd7);
    check("shf_load_leds", bus.leds, 16'h0);
    drive(0, 0, 0, 0, 0, 3'b100, 3'd0, 3'd0, 0, 0);
    tick();
    check("shf_left", 16'(bus.out), 16'b001111);
    tick();
    check("shf_right", 16'(bus.out), 16'b000111);

    // Load 000001, rotate right wraps to 100000, then opcode 110 is invalid.
    drive(1, 0, 0, 0, 0, 3'b000, 3'd1, 3'd0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 3'b101, 3'd0, 3'd0, 0, 0);
    tick();
    check("rot_load", 16'(bus.out), 16'd1);
    drive(0, 0, 0, 0, 0, 3'b110, 3'd0, 3'd0, 0, 0);
    tick();
    check("rot_right", 16'(bus.out), 16'b100000);
    tick();
    check("op110_out", 16'(bus.out), 16'h0);
    check("op110_leds1", bus.leds, 16'hFFFF);
    tick();
    check("op110_leds2", bus.leds, 16'h0000);

    // Reset asserted between edges clears out without a clock edge.
    drive(0, 0, 0, 0, 0, 3'b011, 3'd7, 3'd7, 0, 0);
    tick();
    tick();
    check("mul_before_rst", 16'(bus.out), 16'd49);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_out", 16'(bus.out), 16'h0);
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
